// File: rtl/mic_fir_frame_pkg.sv
// Shared constants and address layout for the mic-array FIR frame buffer.
// Address layout is {bank, sample, channel}, with the bank in the MSB.
package mic_fir_frame_pkg;

  localparam int unsigned DATA_WIDTH     = 16;
  localparam int unsigned CHANNELS       = 8;
  localparam int unsigned CHANNELS_WIDTH = 3;
  localparam int unsigned FRAME_SAMPLES  = 128;
  localparam int unsigned FRAME_WIDTH    = 7;
  localparam int unsigned GAIN_WIDTH     = 4;

  localparam int unsigned ADDR_WIDTH = 1 + FRAME_WIDTH + CHANNELS_WIDTH;
  localparam int unsigned BANK_BIT   = ADDR_WIDTH - 1;
  localparam int unsigned SMP_LSB    = CHANNELS_WIDTH;
  localparam int unsigned CH_LSB     = 0;
  localparam int unsigned BANK_WORDS = FRAME_SAMPLES * CHANNELS;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic                      bank;
    logic [FRAME_WIDTH-1:0]    smp;
    logic [CHANNELS_WIDTH-1:0] ch;
  } frame_addr_t;

  function automatic logic [ADDR_WIDTH-1:0] frame_addr(
    input logic                      bank,
    input logic [FRAME_WIDTH-1:0]    smp,
    input logic [CHANNELS_WIDTH-1:0] ch
  );
    return {bank, smp, ch};
  endfunction

endpackage

// File: rtl/mic_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// The read samples the array before the same-edge write (read-before-write).
module mic_frame_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Storage is not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mic_fir_frame_buffer.sv
// Gains, saturates and packs FIR decimator samples into a ping-pong frame RAM,
// pulsing irq when a bank of FRAME_SAMPLES x CHANNELS samples is complete.
module mic_fir_frame_buffer
  import mic_fir_frame_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  fir_valid,
  input  logic [DATA_WIDTH-1:0] fir_data,
  input  logic [GAIN_WIDTH-1:0] gain_shift,
  input  logic                  irq_ack,
  input  logic                  overrun_clr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  irq,
  output logic                  ready_bank,
  output logic                  pending,
  output logic                  overrun
);

  localparam int unsigned EXT_WIDTH = DATA_WIDTH + (2 ** GAIN_WIDTH) - 1;
  localparam logic signed [EXT_WIDTH-1:0] EXT_MAX = EXT_WIDTH'(SAT_MAX);
  localparam logic signed [EXT_WIDTH-1:0] EXT_MIN = ~EXT_MAX;

  logic [CHANNELS_WIDTH-1:0] ch_cnt_q, ch_cnt_d;
  logic [FRAME_WIDTH-1:0]    smp_cnt_q, smp_cnt_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      wr_en_q, wr_en_d;
  frame_addr_t               wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      irq_q, irq_d;
  logic                      ready_bank_q, ready_bank_d;
  logic                      pending_q, pending_d;
  logic                      overrun_q, overrun_d;

  logic signed [EXT_WIDTH-1:0] ext_c;
  logic signed [EXT_WIDTH-1:0] shifted_c;
  logic [DATA_WIDTH-1:0]       sat_c;
  logic                        accept_c;
  logic                        ch_wrap_c;
  logic                        smp_wrap_c;
  logic                        frame_done_c;

  // The extension is wide enough that the largest shift never loses the sign.
  always_comb begin
    ext_c     = {{(EXT_WIDTH-DATA_WIDTH){fir_data[DATA_WIDTH-1]}}, fir_data};
    shifted_c = ext_c <<< gain_shift;
    if (shifted_c > EXT_MAX) begin
      sat_c = SAT_MAX;
    end else if (shifted_c < EXT_MIN) begin
      sat_c = SAT_MIN;
    end else begin
      sat_c = shifted_c[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    accept_c     = fir_valid && enable;
    ch_wrap_c    = (ch_cnt_q == CHANNELS_WIDTH'(CHANNELS - 1));
    smp_wrap_c   = (smp_cnt_q == FRAME_WIDTH'(FRAME_SAMPLES - 1));
    frame_done_c = accept_c && ch_wrap_c && smp_wrap_c;

    ch_cnt_d     = ch_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    wr_bank_d    = wr_bank_q;
    wr_en_d      = accept_c;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    irq_d        = frame_done_c;
    ready_bank_d = ready_bank_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;

    // Disabled: restart the frame at sample 0, channel 0 of the current bank.
    if (!enable) begin
      ch_cnt_d  = '0;
      smp_cnt_d = '0;
    end else if (fir_valid) begin
      wr_addr_d = '{bank: wr_bank_q, smp: smp_cnt_q, ch: ch_cnt_q};
      wr_data_d = sat_c;
      ch_cnt_d  = ch_wrap_c ? '0 : ch_cnt_q + CHANNELS_WIDTH'(1);
      if (ch_wrap_c) begin
        smp_cnt_d = smp_wrap_c ? '0 : smp_cnt_q + FRAME_WIDTH'(1);
        if (smp_wrap_c) begin
          wr_bank_d = ~wr_bank_q;
        end
      end
    end

    // Completion beats a coincident ack; a set beats a coincident overrun_clr.
    if (frame_done_c) begin
      ready_bank_d = wr_bank_q;
      pending_d    = 1'b1;
    end else if (irq_ack) begin
      pending_d = 1'b0;
    end

    if (frame_done_c && pending_q && !irq_ack) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      ch_cnt_q     <= '0;
      smp_cnt_q    <= '0;
      wr_bank_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      irq_q        <= 1'b0;
      ready_bank_q <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ch_cnt_q     <= ch_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      wr_bank_q    <= wr_bank_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      irq_q        <= irq_d;
      ready_bank_q <= ready_bank_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  mic_frame_ram #(
    .DATA_W (DATA_WIDTH),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign irq        = irq_q;
  assign ready_bank = ready_bank_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mic_fir_frame_buffer.sv
// Self-checking bench for mic_fir_frame_buffer against a frame-position model.
module tb_mic_fir_frame_buffer;
  import mic_fir_frame_pkg::*;

  logic                  clk;
  logic                  resetn;
  logic                  enable;
  logic                  fir_valid;
  logic [DATA_WIDTH-1:0] fir_data;
  logic [GAIN_WIDTH-1:0] gain_shift;
  logic                  irq_ack;
  logic                  overrun_clr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  irq;
  logic                  ready_bank;
  logic                  pending;
  logic                  overrun;

  mic_fir_frame_buffer dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .fir_valid   (fir_valid),
    .fir_data    (fir_data),
    .gain_shift  (gain_shift),
    .irq_ack     (irq_ack),
    .overrun_clr (overrun_clr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .irq         (irq),
    .ready_bank  (ready_bank),
    .pending     (pending),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bank index plus linear position within the bank.
  int       m_bank = 0;
  int       m_pos = 0;
  bit       m_irq = 0;
  bit       m_rb = 0;
  bit       m_pend = 0;
  bit       m_ovr = 0;
  bit       cur_en = 0;
  logic [DATA_WIDTH-1:0] m_mem [2*BANK_WORDS];
  bit       m_known [2*BANK_WORDS];

  function automatic logic [DATA_WIDTH-1:0] sat_m(input logic [DATA_WIDTH-1:0] d, input int g);
    longint x;
    x = longint'($signed(d)) * (longint'(1) << g);
    if (x > 32767) return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit v, input logic [15:0] d,
                      input logic [3:0] g, input bit ack, input bit oclr);
    bit done;
    int a;
    resetn = rst; enable = en; fir_valid = v; fir_data = d;
    gain_shift = g; irq_ack = ack; overrun_clr = oclr;
    cur_en = en;
    done = 0;
    if (rst) begin
      m_bank = 0; m_pos = 0; m_irq = 0; m_rb = 0; m_pend = 0; m_ovr = 0;
    end else begin
      m_irq = 0;
      if (!en) begin
        m_pos = 0;
      end else if (v) begin
        a = m_bank * BANK_WORDS + m_pos;
        m_mem[a] = sat_m(d, int'(g));
        m_known[a] = 1;
        if (m_pos == BANK_WORDS - 1) begin
          done = 1;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
      if (done) begin
        if (m_pend && !ack) m_ovr = 1;
        else if (oclr) m_ovr = 0;
        m_pend = 1;
        m_irq = 1;
        m_rb = m_bank[0];
        m_bank ^= 1;
      end else begin
        if (ack) m_pend = 0;
        if (oclr) m_ovr = 0;
      end
    end
    @(posedge clk); #1;
    check("irq", 32'(irq), 32'(m_irq));
    check("pending", 32'(pending), 32'(m_pend));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("ready_bank", 32'(ready_bank), 32'(m_rb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, cur_en, 0, 16'h0, 4'h0, 0, 0);
  endtask

  task automatic strobe(input logic [15:0] d, input logic [3:0] g);
    step(0, 1, 1, d, g, 0, 0);
  endtask

  task automatic rand_strobes(input int n, input bit gaps);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) idle(1);
      d = 16'($urandom);
      if ($urandom_range(1) == 1) d = {{8{d[7]}}, d[7:0]};
      strobe(d, 4'($urandom_range(15)));
    end
  endtask

  // Caller guarantees at least one idle cycle since the last write.
  task automatic read_chk(input int a);
    rd_addr = ADDR_WIDTH'(a);
    idle(1);
    if (m_known[a]) check($sformatf("rd[%0h]", a), 32'(rd_data), 32'(m_mem[a]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1; enable = 0; fir_valid = 0; fir_data = '0; gain_shift = '0;
    irq_ack = 0; overrun_clr = 0; rd_addr = '0;

    // Reset state
    step(1, 0, 0, 16'h0, 4'h0, 0, 0);
    step(1, 0, 0, 16'h0, 4'h0, 0, 0);
    check("rst_rd_data", 32'(rd_data), 32'h0);

    // Eight pass-through strobes
    for (int i = 0; i < 8; i++) strobe(16'h0100, 4'h0);
    idle(1);
    for (int i = 0; i < 8; i++) read_chk(i);
    rd_addr = frame_addr(1'b0, 7'd0, 3'd3);
    idle(1);
    check("rd_003_lit", 32'(rd_data), 32'h0100);

    // Gain saturation
    strobe(16'h1000, 4'd4);
    strobe(16'hF000, 4'd4);
    strobe(16'h0123, 4'd4);
    rand_strobes(5, 0);
    idle(1);
    rd_addr = frame_addr(1'b0, 7'd1, 3'd0); idle(1);
    check("sat_pos", 32'(rd_data), 32'h7FFF);
    rd_addr = frame_addr(1'b0, 7'd1, 3'd1); idle(1);
    check("sat_neg", 32'(rd_data), 32'h8000);
    rd_addr = frame_addr(1'b0, 7'd1, 3'd2); idle(1);
    check("gain_x16", 32'(rd_data), 32'h1230);
    for (int i = 11; i < 16; i++) read_chk(i);

    // Complete bank 0 with occasional gaps
    rand_strobes(BANK_WORDS - 16, 1);
    check("bank0_irq", 32'(irq), 32'h1);
    check("bank0_rb", 32'(ready_bank), 32'h0);
    check("bank0_pend", 32'(pending), 32'h1);
    strobe(16'h2468, 4'd0);
    idle(1);
    read_chk(BANK_WORDS);
    for (int i = 0; i < 24; i++) read_chk($urandom_range(BANK_WORDS - 1));

    // Bank 1 completes while bank 0 still pending
    rand_strobes(BANK_WORDS - 1, 0);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_rb", 32'(ready_bank), 32'h1);
    step(0, 1, 0, 16'h0, 4'h0, 0, 1);
    check("ovr_clr", 32'(overrun), 32'h0);

    // Third completion with a coincident ack
    rand_strobes(BANK_WORDS - 1, 0);
    step(0, 1, 1, 16'h1357, 4'd1, 1, 0);
    check("ack_coinc_pend", 32'(pending), 32'h1);
    check("ack_coinc_ovr", 32'(overrun), 32'h0);
    step(0, 1, 0, 16'h0, 4'h0, 1, 0);
    check("ack_clr", 32'(pending), 32'h0);

    // Reset mid-frame
    rand_strobes(300, 0);
    rd_addr = ADDR_WIDTH'(5);
    step(1, 1, 0, 16'h0, 4'h0, 0, 0);
    check("midrst_rd", 32'(rd_data), 32'h0);
    strobe(16'h0BEE, 4'd2);
    idle(1);
    rd_addr = frame_addr(1'b0, 7'd0, 3'd0); idle(1);
    check("midrst_addr0", 32'(rd_data), 32'h2FB8);
    rand_strobes(BANK_WORDS - 1, 1);
    check("midrst_irq", 32'(irq), 32'h1);

    // Enable dropped then raised, now in bank 1
    rand_strobes(5, 0);
    step(0, 0, 1, 16'h7777, 4'd0, 0, 0);
    step(0, 0, 1, 16'h6666, 4'd0, 0, 0);
    step(0, 0, 1, 16'h5555, 4'd0, 0, 0);
    step(0, 1, 1, 16'h5A5A, 4'd0, 0, 0);
    idle(1);
    rd_addr = frame_addr(1'b1, 7'd0, 3'd0); idle(1);
    check("reen_addr", 32'(rd_data), 32'h5A5A);
    for (int i = 0; i < 8; i++) read_chk(BANK_WORDS + i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
